// File: rtl/proc_pkg.sv
// Shared mode codes, FSM states and video timing for the
// camera-to-VGA processing-mode controller.
package proc_pkg;

  localparam logic [2:0] MODE_NORMAL = 3'b000;
  localparam logic [2:0] MODE_BRIGHT = 3'b001;
  localparam logic [2:0] MODE_BLUR   = 3'b101;
  localparam logic [2:0] MODE_EDGE   = 3'b110;
  localparam logic [2:0] MODE_GAME   = 3'b111;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    FLUSH
  } state_t;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int PAD   = 2;

  // Modes whose stages need line buffers filled before output is valid
  function automatic logic needs_warm(input logic [2:0] m);
    return (m == MODE_BLUR) || (m == MODE_EDGE);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter for the mode switches.
// candidate only follows sw after it has been steady long enough.
module sw_debounce #(
  parameter int STABLE_CYC = 1024,
  parameter int W          = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  output logic [W-1:0] candidate
);

  localparam int CW = $clog2(STABLE_CYC) + 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC - 1);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [W-1:0]  s3;
  logic [CW-1:0] cnt;
  logic          chg;

  assign chg = (s2 != s3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      cnt       <= '0;
      candidate <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      s3 <= s2;
      if (chg)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
      if (!chg && cnt == CMAX)
        candidate <= s2;
    end
  end

endmodule

// File: rtl/proc_mode_ctrl.sv
// Frame-synchronous mode controller: applies debounced mode changes at
// vsync, masks output during line-buffer warm-up, strobes blur padding.
module proc_mode_ctrl
  import proc_pkg::*;
#(
  parameter int STABLE_CYC = 1024,
  parameter int WARM_LINES = 2,
  parameter int H_ACT      = proc_pkg::H_ACT,
  parameter int V_ACT      = proc_pkg::V_ACT,
  parameter int PAD        = proc_pkg::PAD,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               vga_reset,
  input  logic [2:0]         mode_sw,
  input  logic               vga_vs_n,
  input  logic [12:0]        row,
  input  logic [12:0]        col,
  output logic [2:0]         active_mode,
  output logic               bright_en,
  output logic               blur_en,
  output logic               edge_en,
  output logic               game_en,
  output logic               pad_zero,
  output logic               out_mask,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int LW = $clog2(WARM_LINES + 1) + 1;
  localparam logic [LW-1:0] WARM = LW'(WARM_LINES);
  localparam logic [12:0] H_A  = 13'(H_ACT);
  localparam logic [12:0] V_A  = 13'(V_ACT);
  localparam logic [12:0] P_A  = 13'(PAD);
  localparam logic [12:0] H_HI = 13'(H_ACT - PAD);
  localparam logic [12:0] V_HI = 13'(V_ACT - PAD);

  logic [2:0] candidate;

  sw_debounce #(
    .STABLE_CYC(STABLE_CYC),
    .W         (3)
  ) u_deb (
    .clk      (clk),
    .rst      (vga_reset),
    .sw       (mode_sw),
    .candidate(candidate)
  );

  logic vs_s1, vs_s2, vs_d;
  logic frame_start;
  logic [12:0] row_r, col_r, col_rr;
  logic line_start;

  assign frame_start = vs_d & ~vs_s2;
  assign line_start  = (col_r == '0) && (col_rr != '0) && (row_r < V_A);

  always_ff @(posedge clk or posedge vga_reset) begin
    if (vga_reset) begin
      vs_s1     <= 1'b1;
      vs_s2     <= 1'b1;
      vs_d      <= 1'b1;
      row_r     <= '0;
      col_r     <= '0;
      col_rr    <= '0;
      frame_cnt <= '0;
    end else begin
      vs_s1  <= vga_vs_n;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
      row_r  <= row;
      col_r  <= col;
      col_rr <= col_r;
      if (frame_start)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  state_t        state, state_n;
  logic [2:0]    pending, pend_n;
  logic [2:0]    active_n;
  logic          mask_n;
  logic [LW-1:0] line_cnt, lcnt_n;
  logic          ret_flush, retf_n;

  always_ff @(posedge clk or posedge vga_reset) begin
    if (vga_reset) begin
      state       <= RUN;
      pending     <= MODE_NORMAL;
      active_mode <= MODE_NORMAL;
      out_mask    <= 1'b0;
      line_cnt    <= '0;
      ret_flush   <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pend_n;
      active_mode <= active_n;
      out_mask    <= mask_n;
      line_cnt    <= lcnt_n;
      ret_flush   <= retf_n;
    end
  end

  always_comb begin
    state_n  = state;
    pend_n   = pending;
    active_n = active_mode;
    mask_n   = out_mask;
    lcnt_n   = line_cnt;
    retf_n   = ret_flush;
    unique case (state)
      RUN: begin
        if (candidate != active_mode) begin
          pend_n  = candidate;
          retf_n  = 1'b0;
          state_n = PEND;
        end
      end
      PEND: begin
        if (candidate == active_mode) begin
          state_n = ret_flush ? FLUSH : RUN;
        end else if (frame_start) begin
          active_n = pending;
          pend_n   = candidate;
          if (needs_warm(pending)) begin
            mask_n  = 1'b1;
            lcnt_n  = '0;
            state_n = FLUSH;
          end else begin
            mask_n  = 1'b0;
            state_n = RUN;
          end
        end else begin
          pend_n = candidate;
        end
      end
      FLUSH: begin
        if (line_start)
          lcnt_n = line_cnt + 1'b1;
        if (candidate != active_mode) begin
          pend_n  = candidate;
          retf_n  = 1'b1;
          state_n = PEND;
        end else if (lcnt_n >= WARM) begin
          mask_n  = 1'b0;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    busy = (state != RUN);
  end

  logic border;

  assign border = (row < P_A) || (row >= V_HI) ||
                  (col < P_A) || (col >= H_HI) ||
                  (row >= V_A) || (col >= H_A);

  always_ff @(posedge clk or posedge vga_reset) begin
    if (vga_reset) begin
      bright_en <= 1'b0;
      blur_en   <= 1'b0;
      edge_en   <= 1'b0;
      game_en   <= 1'b0;
      pad_zero  <= 1'b0;
    end else begin
      bright_en <= (active_mode == MODE_BRIGHT);
      blur_en   <= (active_mode == MODE_BLUR);
      edge_en   <= (active_mode == MODE_EDGE);
      game_en   <= (active_mode == MODE_GAME);
      pad_zero  <= blur_en & border;
    end
  end

endmodule

// File: tb/tb_proc_mode_ctrl.sv
// Directed bench for proc_mode_ctrl with a small frame geometry.
// Vector tables for mode decode and pad border plus sequences.
module tb_proc_mode_ctrl;

  logic        clk = 1'b0;
  logic        vga_reset;
  logic [2:0]  mode_sw;
  logic        vga_vs_n;
  logic [12:0] row;
  logic [12:0] col;
  logic [2:0]  active_mode;
  logic        bright_en, blur_en, edge_en, game_en;
  logic        pad_zero, out_mask, busy;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  proc_mode_ctrl #(
    .STABLE_CYC(4),
    .WARM_LINES(2),
    .H_ACT     (16),
    .V_ACT     (8),
    .PAD       (2),
    .FRAME_W   (8)
  ) dut (
    .clk        (clk),
    .vga_reset  (vga_reset),
    .mode_sw    (mode_sw),
    .vga_vs_n   (vga_vs_n),
    .row        (row),
    .col        (col),
    .active_mode(active_mode),
    .bright_en  (bright_en),
    .blur_en    (blur_en),
    .edge_en    (edge_en),
    .game_en    (game_en),
    .pad_zero   (pad_zero),
    .out_mask   (out_mask),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [2:0] m;
    logic [3:0] en;
    logic       mask;
  } mode_vec_t;

  typedef struct {
    logic [12:0] r;
    logic [12:0] c;
    logic        pz;
  } pad_vec_t;

  mode_vec_t mtab[7];
  pad_vec_t  ptab[15];

  int checks = 0;
  int errors = 0;
  int frames = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic vsync();
    vga_vs_n = 1'b0;
    tick(3);
    vga_vs_n = 1'b1;
    tick(3);
    frames++;
  endtask

  task automatic set_mode(input logic [2:0] m);
    mode_sw = m;
    tick(10);
  endtask

  task automatic scan_line(input int r);
    row = 13'(r);
    col = 13'd19;
    tick(1);
    for (int c = 0; c < 20; c++) begin
      col = 13'(c);
      tick(1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " active_mode"}, 32'(active_mode), 0);
    chk({tag, " enables"},
        32'({bright_en, blur_en, edge_en, game_en}), 0);
    chk({tag, " pad_zero"}, 32'(pad_zero), 0);
    chk({tag, " out_mask"}, 32'(out_mask), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  initial begin
    mtab = '{
      '{3'b010, 4'b0000, 1'b0},
      '{3'b011, 4'b0000, 1'b0},
      '{3'b100, 4'b0000, 1'b0},
      '{3'b110, 4'b0010, 1'b1},
      '{3'b111, 4'b0001, 1'b0},
      '{3'b001, 4'b1000, 1'b0},
      '{3'b000, 4'b0000, 1'b0}
    };
    ptab = '{
      '{13'd0,    13'd5,  1'b1},
      '{13'd5,    13'd15, 1'b1},
      '{13'd7,    13'd3,  1'b1},
      '{13'd3,    13'd3,  1'b0},
      '{13'd1,    13'd8,  1'b1},
      '{13'd2,    13'd8,  1'b0},
      '{13'd5,    13'd8,  1'b0},
      '{13'd6,    13'd8,  1'b1},
      '{13'd3,    13'd13, 1'b0},
      '{13'd3,    13'd14, 1'b1},
      '{13'd3,    13'd1,  1'b1},
      '{13'd3,    13'd2,  1'b0},
      '{13'd8,    13'd3,  1'b1},
      '{13'd3,    13'd16, 1'b1},
      '{13'h1FFF, 13'd3,  1'b1}
    };

    vga_reset = 1'b1;
    mode_sw   = 3'b000;
    vga_vs_n  = 1'b1;
    row       = '0;
    col       = '0;
    tick(3);
    chk_all_zero("reset");
    vga_reset = 1'b0;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      mode_sw = (i % 2 == 0) ? 3'b110 : 3'b000;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        chk("bounce busy", 32'(busy), 0);
      end
    end
    set_mode(3'b000);
    chk("bounce busy settled", 32'(busy), 0);
    chk("bounce active", 32'(active_mode), 0);

    set_mode(3'b001);
    chk("bright pend busy", 32'(busy), 1);
    chk("bright pend active", 32'(active_mode), 0);
    vsync();
    chk("bright active", 32'(active_mode), 32'h1);
    chk("bright_en", 32'(bright_en), 1);
    chk("bright mask", 32'(out_mask), 0);
    chk("bright busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      set_mode(mtab[i].m);
      vsync();
      chk("decode active", 32'(active_mode), 32'(mtab[i].m));
      chk("decode enables",
          32'({bright_en, blur_en, edge_en, game_en}),
          32'(mtab[i].en));
      chk("decode mask", 32'(out_mask), 32'(mtab[i].mask));
      chk("decode busy", 32'(busy), 32'(mtab[i].mask));
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(frames % 256));

    set_mode(3'b101);
    vsync();
    chk("warm active", 32'(active_mode), 32'h5);
    chk("warm blur_en", 32'(blur_en), 1);
    chk("warm mask start", 32'(out_mask), 1);
    scan_line(0);
    chk("warm mask line1", 32'(out_mask), 1);
    chk("warm busy line1", 32'(busy), 1);
    scan_line(1);
    chk("warm mask line2", 32'(out_mask), 0);
    chk("warm busy line2", 32'(busy), 0);

    for (int i = 0; i < 15; i++) begin
      row = ptab[i].r;
      col = ptab[i].c;
      tick(2);
      chk("pad_zero", 32'(pad_zero), 32'(ptab[i].pz));
    end

    set_mode(3'b110);
    chk("cancel pend busy", 32'(busy), 1);
    set_mode(3'b101);
    chk("cancel busy", 32'(busy), 0);
    vsync();
    chk("cancel active", 32'(active_mode), 32'h5);
    chk("cancel mask", 32'(out_mask), 0);
    chk("cancel busy after vs", 32'(busy), 0);
    chk("frame_cnt", 32'(frame_cnt), 32'(frames % 256));

    while (frames % 256 != 0)
      vsync();
    chk("frame wrap", 32'(frame_cnt), 32'(frames % 256));

    set_mode(3'b110);
    vsync();
    chk("flush mask", 32'(out_mask), 1);
    chk("flush busy", 32'(busy), 1);
    #2;
    vga_reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    tick(1);
    vga_reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_mode_ctrl.md
Name: proc_mode_ctrl

Overview:
- Frame-synchronous mode controller for the camera-to-VGA pixel pipeline. It sequences the brightness, blur, edge-detect and game stages.
- Debounces the 3-bit mode select from SW[9:7]. A mode change is applied only at a vertical-sync boundary.
- Masks output while the line-buffered stages (blur, edge) warm up.
- Generates the zero-pad strobe for the 5x5 blur border.
- Sits between the switch inputs and the datapath enables in the top level. Runs on the 50 MHz system clock.

Parameters:
- STABLE_CYC, 1024: cycles mode_sw must hold steady before it is accepted as the candidate mode.
- WARM_LINES, 2: line starts counted after a blur/edge mode is applied before the output mask drops.
- H_ACT, 640: active columns.
- V_ACT, 480: active rows.
- PAD, 2: border width, in pixels, that is zeroed on every side for the blur.
- FRAME_W, 8: width of the frame counter.

Ports:
- clk  in  1  50 MHz system clock.
- vga_reset  in  1  asynchronous, active-high reset.
- mode_sw  in  3  raw {SW[9],SW[8],SW[7]}, asynchronous.
- vga_vs_n  in  1  active-low VGA vsync; 2FF-synchronised internally.
- row  in  13  y_count minus the vertical offset. Values before the active area wrap to large unsigned numbers.
- col  in  13  x_count minus the horizontal offset, same wrap rule.
- active_mode  out  3  mode currently applied.
- bright_en  out  1  greyscale/contrast enable.
- blur_en  out  1  5x5 blur enable.
- edge_en  out  1  edge-detect enable.
- game_en  out  1  game overlay enable.
- pad_zero  out  1  blur input must be forced to 0 this cycle.
- out_mask  out  1  pipeline warming up; downstream drives black.
- busy  out  1  a mode change is pending or warming up.
- frame_cnt  out  FRAME_W  number of frame starts seen; wraps.

Behaviour:
- Reset (async, any time):
  - active_mode=000; all enables 0; pad_zero=0; out_mask=0; busy=0; frame_cnt=0.
  - Candidate=000; debounce counter=0; state RUN.
  - Sync flops for vga_vs_n reset to 1; sync flops for mode_sw reset to 000.
- Mode decode:
  - 000 normal; 001 bright; 101 blur; 110 edge; 111 game.
  - 010, 011, 100 are reserved and decode as normal.
  - At most one enable is high. Enables are registered and change on the cycle after active_mode changes.
- Debounce:
  - mode_sw passes through a 2FF synchroniser.
  - The counter clears on any change of the synchronised value and otherwise increments, saturating.
  - When it reaches STABLE_CYC-1, candidate <= synchronised value.
- Frame start: a 1-cycle pulse on the synchronised falling edge of vga_vs_n. frame_cnt increments on every pulse and wraps from all-ones to 0.
- Line start: registered col==0 while the previous registered col!=0 and row<V_ACT.
- FSM state RUN:
  - busy=0.
  - If candidate!=active_mode: pending <= candidate; go to PEND.
- FSM state PEND:
  - busy=1.
  - If candidate==active_mode: cancel and return to the prior state (RUN, or FLUSH with its line count kept).
  - Else if the candidate changes: pending <= candidate.
  - On frame start: active_mode <= pending as held at that cycle. A candidate update in the same cycle is kept as the new pending and re-enters PEND next cycle.
  - If the applied mode decodes to blur or edge: out_mask=1, line_cnt=0, go to FLUSH. Otherwise out_mask=0, go to RUN.
- FSM state FLUSH:
  - busy=1; out_mask=1.
  - line_cnt increments on each line start.
  - When line_cnt reaches WARM_LINES: out_mask <= 0, go to RUN.
  - A frame start during FLUSH does not reset line_cnt.
  - A candidate!=active_mode during FLUSH: go to PEND, keeping out_mask=1.
- pad_zero:
  - Registered, 1-cycle latency from row/col, with row/col compared as unsigned.
  - Equals blur_en and (row<PAD or row>=V_ACT-PAD or col<PAD or col>=H_ACT-PAD or row>=V_ACT or col>=H_ACT).
- No combinational path from any input to any output.

Decomposition:
- Shared package proc_pkg holds:
  - Mode codes: MODE_NORMAL=3'b000, MODE_BRIGHT=3'b001, MODE_BLUR=3'b101, MODE_EDGE=3'b110, MODE_GAME=3'b111.
  - FSM state typedef {RUN, PEND, FLUSH}.
  - Timing constants H_ACT, V_ACT, PAD.
- One sub-module, sw_debounce: the 2FF synchroniser plus stable counter. Parameter STABLE_CYC; output candidate.

Test Plan:
- Reset behaviour. Bench uses STABLE_CYC=4, H_ACT=16, V_ACT=8. Assert vga_reset mid-FLUSH -> all outputs 0 and active_mode=000 immediately, without waiting for a clock edge.
- Mode 001 applied at frame start. mode_sw=001 held 4 cycles, then a vsync fall -> active_mode=001 and bright_en=1 one cycle after the frame start; out_mask stays 0; busy returns to 0.
- Switch bounce. mode_sw toggles 000/110 every 2 cycles for 20 cycles, then settles at 000 -> candidate never changes; state stays RUN; busy=0 throughout.
- Blur warm-up. Select 101, frame start -> out_mask=1 until the 2nd line start, then 0.
- Blur padding. With blur active, pad_zero=1 at (row=0,col=5), (row=5,col=15) and (row=7,col=3); pad_zero=0 at (row=3,col=3).
- Change cancelled and frame counter wrap. PEND to 110, then mode_sw back to the active 101 before vsync -> active_mode stays 101 and no FLUSH occurs. 256 frame starts -> frame_cnt wraps to 0.
